// File: rtl/cmd_slot_if.sv
// Capture and replay signal bundle of the command slot sequencer.
// master drives capture/replay controls; slave is the sequencer itself.
interface cmd_slot_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 3
) ();
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] wdata;
    logic              cap_en;
    logic              clr;
    logic              alu_en;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [ADDR_W-1:0] out_idx;
    logic              done;
    logic [DEPTH-1:0]  vld_mask;
    logic [1:0]        state_dbg;

    // Handshake: a word moves on every rising edge where out_valid && out_ready.
    // While out_valid is high and no transfer happens, out_data/out_idx hold stable.
    modport master (
        output wdata, cap_en, clr, alu_en, out_ready,
        input  out_data, out_valid, out_idx, done, vld_mask, state_dbg
    );

    modport slave (
        input  wdata, cap_en, clr, alu_en, out_ready,
        output out_data, out_valid, out_idx, done, vld_mask, state_dbg
    );
endinterface

// File: rtl/cmd_slot_sequencer.sv
// Command slot store: words are captured by an address field in the word and
// replayed in ascending slot order over a valid/ready stream.
module cmd_slot_sequencer #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 3,
    parameter int ADDR_LSB   = 19,
    parameter int SKIP_EMPTY = 1
) (
    input  logic       clk,
    input  logic       rst,
    cmd_slot_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] slot_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] cap_addr;
    logic              first_found, next_found;
    logic [ADDR_W-1:0] first_idx, next_idx;
    logic [DATA_W-1:0] first_word, next_word;

    assign cap_addr = bus.wdata[ADDR_LSB +: ADDR_W];

    // Slot storage deliberately has no reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (bus.cap_en) begin
            slot_q[cap_addr] <= bus.wdata;
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (bus.clr) begin
            vld_d = '0;
        end
        if (bus.cap_en) begin
            vld_d[cap_addr] = 1'b1;
        end
    end

    // Slot search works on pre-edge valid bits, so same-edge captures are not seen.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        if (SKIP_EMPTY != 0) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (vld_q[i]) begin
                    first_found = 1'b1;
                    first_idx   = ADDR_W'(i);
                end
                if (vld_q[i] && (i > int'(out_idx_q))) begin
                    next_found = 1'b1;
                    next_idx   = ADDR_W'(i);
                end
            end
        end else begin
            first_found = 1'b1;
            first_idx   = '0;
            next_found  = (out_idx_q != {ADDR_W{1'b1}});
            next_idx    = out_idx_q + ADDR_W'(1);
        end
    end

    assign first_word = vld_q[first_idx] ? slot_q[first_idx] : '0;
    assign next_word  = vld_q[next_idx]  ? slot_q[next_idx]  : '0;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        done_d      = done_q;
        if (!bus.alu_en) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (first_found) begin
                        state_d     = PLAY;
                        out_data_d  = first_word;
                        out_idx_d   = first_idx;
                        out_valid_d = 1'b1;
                        done_d      = 1'b0;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
                PLAY: begin
                    if (out_valid_q && bus.out_ready) begin
                        if (next_found) begin
                            out_data_d = next_word;
                            out_idx_d  = next_idx;
                        end else begin
                            state_d     = DONE;
                            out_valid_d = 1'b0;
                            done_d      = 1'b1;
                        end
                    end
                end
                DONE: begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    done_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vld_q       <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.vld_mask  = vld_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_cmd_slot_sequencer.sv
// Directed bench: one sequencer with empty-slot skipping, one without, sharing
// the same capture/replay stimulus.
module tb_cmd_slot_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    cmd_slot_if #(.DATA_W(24), .ADDR_W(3)) bus_s ();
    cmd_slot_if #(.DATA_W(24), .ADDR_W(3)) bus_n ();

    assign bus_n.wdata     = bus_s.wdata;
    assign bus_n.cap_en    = bus_s.cap_en;
    assign bus_n.clr       = bus_s.clr;
    assign bus_n.alu_en    = bus_s.alu_en;
    assign bus_n.out_ready = bus_s.out_ready;

    cmd_slot_sequencer #(.DATA_W(24), .ADDR_W(3), .ADDR_LSB(19), .SKIP_EMPTY(1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    cmd_slot_sequencer #(.DATA_W(24), .ADDR_W(3), .ADDR_LSB(19), .SKIP_EMPTY(0)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] exp_word(input logic [2:0] a);
        logic [15:0] d;
        d = 16'h00A5 << a[1:0];
        return {2'b00, a, 3'b000, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap_word(input logic [23:0] w);
        bus_s.wdata  = w;
        bus_s.cap_en = 1'b1;
        step();
        bus_s.cap_en = 1'b0;
    endtask

    task automatic clr_pulse();
        bus_s.clr = 1'b1;
        step();
        bus_s.clr = 1'b0;
    endtask

    task automatic stop_replay();
        bus_s.alu_en = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++; if (bus_s.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus_s.out_valid); else n_pass++;
        n_checks++; if (bus_s.out_data !== 24'h0) $display("FAIL reset_data: got %h want 000000", bus_s.out_data); else n_pass++;
        n_checks++; if (bus_s.out_idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", bus_s.out_idx); else n_pass++;
        n_checks++; if (bus_s.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus_s.done); else n_pass++;
        n_checks++; if (bus_s.vld_mask !== 8'h00) $display("FAIL reset_vld: got %h want 00", bus_s.vld_mask); else n_pass++;
        n_checks++; if (bus_s.state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", bus_s.state_dbg); else n_pass++;
        n_checks++; if (bus_n.out_valid !== 1'b0) $display("FAIL reset_valid_n: got %b want 0", bus_n.out_valid); else n_pass++;
    endtask

    task automatic test_full_replay();
        for (int a = 7; a >= 0; a--) cap_word(exp_word(3'(a)));
        n_checks++; if (bus_s.vld_mask !== 8'hFF) $display("FAIL full_vld: got %h want ff", bus_s.vld_mask); else n_pass++;
        bus_s.alu_en    = 1'b1;
        bus_s.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++; if (bus_s.out_valid !== 1'b1) $display("FAIL full_valid[%0d]: got %b want 1", i, bus_s.out_valid); else n_pass++;
            n_checks++; if (bus_s.out_idx !== 3'(i)) $display("FAIL full_idx[%0d]: got %0d want %0d", i, bus_s.out_idx, i); else n_pass++;
            n_checks++; if (bus_s.out_data !== exp_word(3'(i))) $display("FAIL full_data[%0d]: got %h want %h", i, bus_s.out_data, exp_word(3'(i))); else n_pass++;
        end
        step();
        n_checks++; if (bus_s.done !== 1'b1) $display("FAIL full_done: got %b want 1", bus_s.done); else n_pass++;
        n_checks++; if (bus_s.out_valid !== 1'b0) $display("FAIL full_end_valid: got %b want 0", bus_s.out_valid); else n_pass++;
        n_checks++; if (bus_s.state_dbg !== 2'd2) $display("FAIL full_state: got %0d want 2", bus_s.state_dbg); else n_pass++;
        stop_replay();
        n_checks++; if (bus_s.done !== 1'b0) $display("FAIL full_done_drop: got %b want 0", bus_s.done); else n_pass++;
    endtask

    task automatic test_sparse();
        clr_pulse();
        cap_word(24'h100203);
        cap_word(24'h2805FF);
        n_checks++; if (bus_s.vld_mask !== 8'h24) $display("FAIL sparse_vld: got %h want 24", bus_s.vld_mask); else n_pass++;
        bus_s.alu_en    = 1'b1;
        bus_s.out_ready = 1'b1;
        step();
        n_checks++; if ({bus_s.out_valid, bus_s.out_idx, bus_s.out_data} !== {1'b1, 3'd2, 24'h100203})
            $display("FAIL sparse_beat0: got v=%b idx=%0d data=%h want v=1 idx=2 data=100203", bus_s.out_valid, bus_s.out_idx, bus_s.out_data); else n_pass++;
        step();
        n_checks++; if ({bus_s.out_valid, bus_s.out_idx, bus_s.out_data} !== {1'b1, 3'd5, 24'h2805FF})
            $display("FAIL sparse_beat1: got v=%b idx=%0d data=%h want v=1 idx=5 data=2805ff", bus_s.out_valid, bus_s.out_idx, bus_s.out_data); else n_pass++;
        step();
        n_checks++; if ({bus_s.out_valid, bus_s.done} !== 2'b01) $display("FAIL sparse_done: got v=%b done=%b want v=0 done=1", bus_s.out_valid, bus_s.done); else n_pass++;
        stop_replay();
        clr_pulse();
        n_checks++; if (bus_s.vld_mask !== 8'h00) $display("FAIL empty_vld: got %h want 00", bus_s.vld_mask); else n_pass++;
        bus_s.alu_en = 1'b1;
        step();
        n_checks++; if ({bus_s.out_valid, bus_s.done} !== 2'b01) $display("FAIL empty_done: got v=%b done=%b want v=0 done=1", bus_s.out_valid, bus_s.done); else n_pass++;
        step();
        n_checks++; if ({bus_s.out_valid, bus_s.done} !== 2'b01) $display("FAIL empty_hold: got v=%b done=%b want v=0 done=1", bus_s.out_valid, bus_s.done); else n_pass++;
        stop_replay();
    endtask

    task automatic test_backpressure();
        for (int a = 0; a < 8; a++) cap_word(exp_word(3'(a)));
        bus_s.alu_en    = 1'b1;
        bus_s.out_ready = 1'b1;
        step();
        step();
        n_checks++; if (bus_s.out_idx !== 3'd1) $display("FAIL bp_start_idx: got %0d want 1", bus_s.out_idx); else n_pass++;
        bus_s.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if ({bus_s.out_valid, bus_s.out_idx, bus_s.out_data} !== {1'b1, 3'd1, exp_word(3'd1)})
                $display("FAIL bp_hold[%0d]: got v=%b idx=%0d data=%h want v=1 idx=1 data=%h", i, bus_s.out_valid, bus_s.out_idx, bus_s.out_data, exp_word(3'd1)); else n_pass++;
        end
        bus_s.out_ready = 1'b1;
        step();
        n_checks++; if ({bus_s.out_idx, bus_s.out_data} !== {3'd2, exp_word(3'd2)})
            $display("FAIL bp_resume: got idx=%0d data=%h want idx=2 data=%h", bus_s.out_idx, bus_s.out_data, exp_word(3'd2)); else n_pass++;
        stop_replay();
    endtask

    task automatic test_abort();
        clr_pulse();
        cap_word(exp_word(3'd2));
        cap_word(exp_word(3'd3));
        cap_word(exp_word(3'd4));
        cap_word(exp_word(3'd6));
        n_checks++; if (bus_s.vld_mask !== 8'h5C) $display("FAIL abort_vld: got %h want 5c", bus_s.vld_mask); else n_pass++;
        bus_s.alu_en    = 1'b1;
        bus_s.out_ready = 1'b1;
        step();
        step();
        n_checks++; if (bus_s.out_idx !== 3'd3) $display("FAIL abort_at3: got %0d want 3", bus_s.out_idx); else n_pass++;
        bus_s.alu_en = 1'b0;
        step();
        n_checks++; if ({bus_s.out_valid, bus_s.done} !== 2'b00) $display("FAIL abort_drop: got v=%b done=%b want v=0 done=0", bus_s.out_valid, bus_s.done); else n_pass++;
        n_checks++; if (bus_s.out_data !== exp_word(3'd3)) $display("FAIL abort_keep_data: got %h want %h", bus_s.out_data, exp_word(3'd3)); else n_pass++;
        bus_s.alu_en = 1'b1;
        step();
        n_checks++; if ({bus_s.out_valid, bus_s.out_idx, bus_s.out_data} !== {1'b1, 3'd2, exp_word(3'd2)})
            $display("FAIL abort_restart: got v=%b idx=%0d data=%h want v=1 idx=2 data=%h", bus_s.out_valid, bus_s.out_idx, bus_s.out_data, exp_word(3'd2)); else n_pass++;
        stop_replay();
    endtask

    task automatic test_hazard();
        clr_pulse();
        cap_word(exp_word(3'd1));
        cap_word(exp_word(3'd3));
        bus_s.alu_en    = 1'b1;
        bus_s.out_ready = 1'b1;
        step();
        n_checks++; if ({bus_s.out_idx, bus_s.out_data} !== {3'd1, exp_word(3'd1)})
            $display("FAIL hz_first: got idx=%0d data=%h want idx=1 data=%h", bus_s.out_idx, bus_s.out_data, exp_word(3'd1)); else n_pass++;
        cap_word(24'h18BEEF);
        n_checks++; if ({bus_s.out_idx, bus_s.out_data} !== {3'd3, exp_word(3'd3)})
            $display("FAIL hz_same_edge: got idx=%0d data=%h want idx=3 data=%h", bus_s.out_idx, bus_s.out_data, exp_word(3'd3)); else n_pass++;
        cap_word(24'h30C0DE);
        n_checks++; if ({bus_s.out_valid, bus_s.done} !== 2'b01) $display("FAIL hz_new_not_seen: got v=%b done=%b want v=0 done=1", bus_s.out_valid, bus_s.done); else n_pass++;
        n_checks++; if (bus_s.vld_mask !== 8'h4A) $display("FAIL hz_vld: got %h want 4a", bus_s.vld_mask); else n_pass++;
        stop_replay();
        bus_s.alu_en = 1'b1;
        step();
        step();
        n_checks++; if ({bus_s.out_idx, bus_s.out_data} !== {3'd3, 24'h18BEEF})
            $display("FAIL hz_updated: got idx=%0d data=%h want idx=3 data=18beef", bus_s.out_idx, bus_s.out_data); else n_pass++;
        step();
        n_checks++; if ({bus_s.out_valid, bus_s.out_idx, bus_s.out_data} !== {1'b1, 3'd6, 24'h30C0DE})
            $display("FAIL hz_slot6: got v=%b idx=%0d data=%h want v=1 idx=6 data=30c0de", bus_s.out_valid, bus_s.out_idx, bus_s.out_data); else n_pass++;
        step();
        n_checks++; if (bus_s.done !== 1'b1) $display("FAIL hz_done: got %b want 1", bus_s.done); else n_pass++;
        stop_replay();
    endtask

    task automatic test_clr_cap();
        logic [23:0] want;
        for (int a = 0; a < 8; a++) cap_word(exp_word(3'(a)));
        bus_s.clr = 1'b1;
        cap_word(24'h23ABCD);
        bus_s.clr = 1'b0;
        n_checks++; if (bus_s.vld_mask !== 8'h10) $display("FAIL cc_vld: got %h want 10", bus_s.vld_mask); else n_pass++;
        n_checks++; if (bus_n.vld_mask !== 8'h10) $display("FAIL cc_vld_n: got %h want 10", bus_n.vld_mask); else n_pass++;
        bus_s.alu_en    = 1'b1;
        bus_s.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            want = (i == 4) ? 24'h23ABCD : 24'h000000;
            n_checks++; if ({bus_n.out_valid, bus_n.out_idx, bus_n.out_data} !== {1'b1, 3'(i), want})
                $display("FAIL cc_noskip[%0d]: got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h", i, bus_n.out_valid, bus_n.out_idx, bus_n.out_data, i, want); else n_pass++;
            if (i == 0) begin
                n_checks++; if ({bus_s.out_valid, bus_s.out_idx, bus_s.out_data} !== {1'b1, 3'd4, 24'h23ABCD})
                    $display("FAIL cc_skip_beat: got v=%b idx=%0d data=%h want v=1 idx=4 data=23abcd", bus_s.out_valid, bus_s.out_idx, bus_s.out_data); else n_pass++;
            end else begin
                n_checks++; if ({bus_s.out_valid, bus_s.done} !== 2'b01)
                    $display("FAIL cc_skip_done[%0d]: got v=%b done=%b want v=0 done=1", i, bus_s.out_valid, bus_s.done); else n_pass++;
            end
        end
        step();
        n_checks++; if ({bus_n.out_valid, bus_n.done} !== 2'b01) $display("FAIL cc_noskip_done: got v=%b done=%b want v=0 done=1", bus_n.out_valid, bus_n.done); else n_pass++;
        stop_replay();
    endtask

    task automatic test_reset_mid();
        for (int a = 0; a < 8; a++) cap_word(exp_word(3'(a)));
        bus_s.alu_en    = 1'b1;
        bus_s.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_checks++; if (bus_s.out_idx !== 3'd5) $display("FAIL rm_at5: got %0d want 5", bus_s.out_idx); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if ({bus_s.out_valid, bus_s.done} !== 2'b00) $display("FAIL rm_flags: got v=%b done=%b want v=0 done=0", bus_s.out_valid, bus_s.done); else n_pass++;
        n_checks++; if (bus_s.out_data !== 24'h0) $display("FAIL rm_data: got %h want 000000", bus_s.out_data); else n_pass++;
        n_checks++; if (bus_s.vld_mask !== 8'h00) $display("FAIL rm_vld: got %h want 00", bus_s.vld_mask); else n_pass++;
        bus_s.alu_en = 1'b0;
        step();
        bus_s.alu_en = 1'b1;
        step();
        n_checks++; if ({bus_s.out_valid, bus_s.done} !== 2'b01) $display("FAIL rm_empty_done: got v=%b done=%b want v=0 done=1", bus_s.out_valid, bus_s.done); else n_pass++;
        stop_replay();
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst             = 1'b1;
        bus_s.wdata     = '0;
        bus_s.cap_en    = 1'b0;
        bus_s.clr       = 1'b0;
        bus_s.alu_en    = 1'b0;
        bus_s.out_ready = 1'b0;
        test_reset();
        test_full_replay();
        test_sparse();
        test_backpressure();
        test_abort();
        test_hazard();
        test_clr_cap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cmd_slot_sequencer.md
Name: cmd_slot_sequencer

Overview:
Parametrised command slot store and replay engine, successor to the fixed 8-entry source register.
- Capture side: incoming command words are written into a slot selected by an address field inside the word.
- Replay side: on request, captured slots are streamed in ascending index order to the ALU over a valid/ready handshake.
- Adds per-slot valid tracking, optional skipping of empty slots, backpressure, bulk clear, synchronous reset and a completion flag.

Parameters:
DATA_W, 24, command word width
ADDR_W, 3, slot address width; DEPTH = 2**ADDR_W slots
ADDR_LSB, 19, bit position of the slot address field LSB inside wdata (field = wdata[ADDR_LSB+ADDR_W-1:ADDR_LSB])
SKIP_EMPTY, 1, 1 = replay only valid slots; 0 = replay every slot, with invalid slots emitted as all-zero data

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
wdata  in  DATA_W  command word to capture
cap_en  in  1  capture strobe
clr  in  1  clear all slot valid bits
alu_en  in  1  replay request, level-sensitive
out_ready  in  1  downstream accepts out_data
out_data  out  DATA_W  replayed command word
out_valid  out  1  out_data/out_idx valid
out_idx  out  ADDR_W  slot index of out_data
done  out  1  replay complete (level)
vld_mask  out  DEPTH  per-slot valid bits

Behaviour:
Reset (rst=1 at an edge, overrides everything):
- vld_mask=0, out_data=0, out_valid=0, out_idx=0, done=0, FSM=IDLE.
- Slot storage is not reset.

Capture:
- cap_en=1 at an edge: slot[addr field] <= wdata, vld_mask[addr] <= 1.
- Capture works in every FSM state.

Clear:
- clr=1 clears all vld_mask bits.
- clr and cap_en in the same cycle: clear applies, then the captured slot is set valid (capture wins for its own slot).

Replay FSM, states IDLE, PLAY, DONE:
- IDLE, alu_en=1 sampled at edge k:
  - If a first slot exists, go to PLAY. First slot is 0 when SKIP_EMPTY=0, otherwise the lowest valid index.
  - At edge k, load out_data/out_idx from that slot and set out_valid=1, so the first word is visible in the cycle after k.
  - If SKIP_EMPTY=1 and vld_mask=0: go to DONE at edge k, out_valid stays 0.
- PLAY, transfer = out_valid & out_ready at an edge:
  - Advance to the next slot (next index, or next valid index > out_idx when SKIP_EMPTY=1) and load it at the same edge.
  - With out_ready held high, throughput is one word per cycle.
  - If no next slot exists: out_valid <= 0, go to DONE.
  - Without a transfer, out_data/out_idx/out_valid hold stable.
- DONE: done=1, out_valid=0. Hold while alu_en=1.
- alu_en=0 sampled in any state: next state IDLE, out_valid=0, done=0, out_data retains its last value.
- A re-raised alu_en restarts the replay from the first slot.

Data hazards:
- Slot contents and vld_mask are read with their pre-edge values.
- A capture at the same edge a slot is loaded into out_data does not affect that word.
- A newly validated slot at that edge is not considered for the skip search.
- Captures to slots already emitted in the current replay are not replayed.
- Captures to slots not yet reached are seen when those slots are reached.

SKIP_EMPTY=0:
- An invalid slot is emitted with out_data=0.

Test Plan:
1. DATA_W=24, ADDR_W=3, SKIP_EMPTY=1. Capture addr 7..0 in descending order, each word = {addr,16'hA5<<addr[1:0]} packed at bits 21:19. Then alu_en=1, out_ready=1 -> out_valid high 8 consecutive cycles, out_idx 0..7 with the matching data; done=1 the cycle after the last word.
2. SKIP_EMPTY=1, capture only addr 2 (0x100203) and addr 5 (0x2805FF) -> exactly two beats (idx 2, idx 5), then done. With vld_mask=0, alu_en -> done=1 one cycle later, out_valid never high.
3. Backpressure: out_ready=0 for 3 cycles while idx 1 is presented -> out_data/out_idx unchanged across those cycles. The next index appears the cycle after out_ready returns high.
4. alu_en dropped while idx 3 is presented -> out_valid=0 and done=0 next cycle. Re-raise -> replay restarts at the lowest valid slot.
5. Slots 0..7 valid; clr=1 and cap_en=1 (addr 4, 0x23ABCD) in the same cycle -> vld_mask=8'h10; replay emits only idx 4, data 0x23ABCD. With SKIP_EMPTY=0 -> 8 beats, 0 everywhere except idx 4.
6. rst=1 mid-replay at idx 5 -> next cycle out_valid=0, out_data=0, done=0, vld_mask=0. A following alu_en with SKIP_EMPTY=1 goes straight to done.
